// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch front end:
// reset PC, IM geometry, fetch FSM states and the next-PC source select.
package mips_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int          IM_WORDS_DEF = 32;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_J   = 2'd2,
    SRC_JR  = 2'd3
  } npc_src_e;

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// Core <-> fetch-controller bundle: redirect/stall controls in, PC and status out.
interface im_fetch_ctrl_if #(
  parameter int IM_AW = 5
);

  logic              stall;
  logic              halt_req;
  logic              branch_taken;
  logic [15:0]       branch_off;
  logic              jump;
  logic [25:0]       jump_target;
  logic              jr;
  logic [31:0]       jr_addr;
  logic [31:0]       pc;
  logic [IM_AW-1:0]  im_addr;
  logic [31:0]       pc_plus4;
  logic              fetch_valid;
  logic              fault;
  logic              halted;

  modport master (
    output stall, halt_req, branch_taken, branch_off, jump, jump_target, jr, jr_addr,
    input  pc, im_addr, pc_plus4, fetch_valid, fault, halted
  );

  modport slave (
    input  stall, halt_req, branch_taken, branch_off, jump, jump_target, jr, jr_addr,
    output pc, im_addr, pc_plus4, fetch_valid, fault, halted
  );

endinterface

// File: rtl/im_npc_calc.sv
// Combinational next-PC mux with alignment and IM-window range check.
module im_npc_calc
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic [31:0] pc,
  input  npc_src_e    src,
  input  logic [15:0] branch_off,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] npc,
  output logic        bad
);

  localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(IM_WORDS * 4);

  logic [31:0] seq_s;
  logic [31:0] br_disp_s;

  assign seq_s     = pc + 32'd4;
  assign br_disp_s = {{14{branch_off[15]}}, branch_off, 2'b00};

  // Source mux; all additions wrap modulo 2^32 before the range check.
  always_comb begin
    npc = seq_s;
    case (src)
      SRC_SEQ: npc = seq_s;
      SRC_BR:  npc = seq_s + br_disp_s;
      SRC_J:   npc = {seq_s[31:28], jump_target, 2'b00};
      SRC_JR:  npc = jr_addr;
      default: npc = seq_s;
    endcase
  end

  assign bad = (npc[1:0] != 2'b00) || (npc < PC_RESET) || (npc >= PC_LIMIT);

endmodule

// File: rtl/im_fetch_ctrl.sv
// PC sequencer for the single-cycle MIPS core: BOOT/RUN/HOLD/HALT FSM,
// PC register, and sticky fault on illegal fetch targets.
module im_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  im_fetch_ctrl_if.slave  bus
);

  localparam int IM_AW = $clog2(IM_WORDS);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        halted_q, halted_d;
  logic        fetch_valid_q, fetch_valid_d;

  npc_src_e    src_s;
  logic [31:0] npc_s;
  logic        bad_s;

  // Redirect priority: jr over jump over branch over sequential.
  always_comb begin
    src_s = SRC_SEQ;
    if (bus.jr) begin
      src_s = SRC_JR;
    end else if (bus.jump) begin
      src_s = SRC_J;
    end else if (bus.branch_taken) begin
      src_s = SRC_BR;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  im_npc_calc #(
    .PC_RESET (PC_RESET),
    .IM_WORDS (IM_WORDS)
  ) u_npc (
    .pc          (pc_q),
    .src         (src_s),
    .branch_off  (bus.branch_off),
    .jump_target (bus.jump_target),
    .jr_addr     (bus.jr_addr),
    .npc         (npc_s),
    .bad         (bad_s)
  );

  // Fetch FSM; a bad candidate halts with the PC kept at its last legal value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
          fault_d = fault_q | bad_s;
        end else if (bus.stall) begin
          state_d = ST_HOLD;
        end else if (bad_s) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          pc_d = npc_s;
        end
      end
      ST_HOLD: begin
        if (!bus.stall) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
    fetch_valid_d = (state_d == ST_RUN);
    halted_d      = (state_d == ST_HALT);
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= PC_RESET;
      fault_q       <= 1'b0;
      halted_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      halted_q      <= halted_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.im_addr     = pc_q[IM_AW+1:2];
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fault       = fault_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed plus randomized bench for im_fetch_ctrl against a behavioural PC model.
module tb_im_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] END_PC = 32'h0000_3080;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  im_fetch_ctrl_if #(.IM_AW(5)) bus ();

  im_fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain PC value plus mode flags.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_hold;
  bit          m_halt;
  bit          m_fault;

  function automatic bit legal(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a >= RST_PC) && (a < END_PC);
  endfunction

  function automatic logic [31:0] target(input logic [31:0] pc);
    int          disp;
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    disp = 4 * int'($signed(bus.branch_off));
    if (bus.jr)                return bus.jr_addr;
    else if (bus.jump)         return (nxt & 32'hF000_0000) + {6'd0, bus.jump_target} * 32'd4;
    else if (bus.branch_taken) return nxt + 32'(disp);
    else                       return nxt;
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    if (!rst_n) begin
      m_pc = RST_PC; m_boot = 1'b1; m_hold = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_hold) begin
      m_hold = bus.stall;
    end else begin
      t = target(m_pc);
      if (bus.halt_req) begin
        m_halt = 1'b1;
        if (!legal(t)) m_fault = 1'b1;
      end else if (bus.stall) begin
        m_hold = 1'b1;
      end else if (!legal(t)) begin
        m_halt = 1'b1; m_fault = 1'b1;
      end else begin
        m_pc = t;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("pc",          bus.pc,                   m_pc);
    chk("im_addr",     32'(bus.im_addr),         (m_pc / 32'd4) % 32'd32);
    chk("pc_plus4",    bus.pc_plus4,             m_pc + 32'd4);
    chk("fetch_valid", 32'(bus.fetch_valid),     32'(!m_boot && !m_hold && !m_halt));
    chk("fault",       32'(bus.fault),           32'(m_fault));
    chk("halted",      32'(bus.halted),          32'(m_halt));
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.halt_req = 1'b0; bus.branch_taken = 1'b0; bus.branch_off = 16'h0000;
    bus.jump = 1'b0; bus.jump_target = 26'h0; bus.jr = 1'b0; bus.jr_addr = 32'h0;
  endtask

  task automatic go_jr(input logic [31:0] a);
    idle(); bus.jr = 1'b1; bus.jr_addr = a;
    cyc();
    idle();
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_pc = RST_PC; m_boot = 1'b1; m_hold = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    rst_n = 1'b0;
    idle();

    // Reset then idle fetch.
    cyc();
    chk("rst_pc", bus.pc, 32'h3000);
    chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("boot_pc", bus.pc, 32'h3000);
    chk("boot_valid", 32'(bus.fetch_valid), 32'd1);
    cyc();
    chk("seq1_pc", bus.pc, 32'h3004);
    chk("seq1_im", 32'(bus.im_addr), 32'd1);
    cyc();
    chk("seq2_pc", bus.pc, 32'h3008);
    chk("seq2_im", 32'(bus.im_addr), 32'd2);

    // Jump from 0x3034.
    go_jr(32'h3034);
    chk("jr_pc", bus.pc, 32'h3034);
    bus.jump = 1'b1; bus.jump_target = 26'h0000c0e;
    #1;
    chk("j_plus4", bus.pc_plus4, 32'h3038);
    cyc();
    chk("j_pc", bus.pc, 32'h3038);
    chk("j_im", 32'(bus.im_addr), 32'd14);

    // Backward branch from 0x3030.
    go_jr(32'h3030);
    bus.branch_taken = 1'b1; bus.branch_off = 16'hfffd;
    cyc();
    chk("br_pc", bus.pc, 32'h3028);
    chk("br_im", 32'(bus.im_addr), 32'd10);

    // Stall with a held jump.
    go_jr(32'h300c);
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 26'h0000c1f;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", bus.pc, 32'h300c);
      chk("stall_valid", 32'(bus.fetch_valid), 32'd0);
    end
    bus.stall = 1'b0;
    cyc();
    chk("unstall_pc", bus.pc, 32'h300c);
    chk("unstall_valid", 32'(bus.fetch_valid), 32'd1);
    bus.jump = 1'b0;
    cyc();
    chk("after_pc", bus.pc, 32'h3010);

    // Out-of-range and misaligned jr.
    go_jr(32'h3080);
    chk("oor_fault", 32'(bus.fault), 32'd1);
    chk("oor_halted", 32'(bus.halted), 32'd1);
    chk("oor_pc", bus.pc, 32'h3010);
    chk("oor_valid", 32'(bus.fetch_valid), 32'd0);
    do_reset();
    chk("clr_fault", 32'(bus.fault), 32'd0);
    chk("clr_halted", 32'(bus.halted), 32'd0);
    chk("clr_pc", bus.pc, 32'h3000);
    cyc();
    go_jr(32'h3002);
    chk("mis_fault", 32'(bus.fault), 32'd1);
    chk("mis_pc", bus.pc, 32'h3000);
    do_reset();
    cyc();

    // Priority, then halt with jr.
    bus.jr = 1'b1; bus.jr_addr = 32'h3010; bus.jump = 1'b1; bus.jump_target = 26'h0000c1c;
    bus.branch_taken = 1'b1; bus.branch_off = 16'h0004;
    cyc();
    chk("prio_pc", bus.pc, 32'h3010);
    idle(); bus.halt_req = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h3020;
    cyc();
    chk("halt_pc", bus.pc, 32'h3010);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    idle(); bus.jr = 1'b1; bus.jr_addr = 32'h3040;
    cyc();
    cyc();
    chk("halt_frozen", bus.pc, 32'h3010);
    do_reset();

    // Randomized phase against the model.
    for (int i = 0; i < 600; i++) begin
      bus.stall        = ($urandom_range(0, 9) == 0);
      bus.halt_req     = ($urandom_range(0, 49) == 0);
      bus.jr           = ($urandom_range(0, 7) == 0);
      bus.jump         = ($urandom_range(0, 7) == 0);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.branch_off   = 16'($urandom_range(0, 20)) - 16'd10;
      bus.jump_target  = 26'h0000c00 + 26'($urandom_range(0, 33));
      if ($urandom_range(0, 9) == 0) bus.jr_addr = $urandom;
      else                           bus.jr_addr = RST_PC + 32'($urandom_range(0, 31)) * 32'd4;
      rst_n = !(($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 3) == 0));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
